// File: rtl/seq_check_if.sv
// Serial monitor link: the sampled line bit toward the detector and its match flag back.
interface seq_check_if;
    logic in_sig;
    logic pattern_found;

    modport master (
        output in_sig,
        input  pattern_found
    );

    modport slave (
        input  in_sig,
        output pattern_found
    );
endinterface

// File: rtl/seq_check.sv
// Serial bit-pattern detector: flags, for one cycle, every sample that completes PATTERN
// (MSB = oldest bit) in the recent in_sig history. Overlapping matches each fire.
module seq_check #(
    parameter int                     PATTERN_LEN = 3,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 3'b110
) (
    input  logic  clk,
    input  logic  rst,
    seq_check_if.slave bus
);

    localparam int                FILL_W   = $clog2(PATTERN_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_LEN);

    if (PATTERN_LEN < 1 || PATTERN_LEN > 32) begin : g_bad_len
        $error("seq_check: PATTERN_LEN must be in 1..32");
    end

    function automatic logic [FILL_W-1:0] sat_inc(input logic [FILL_W-1:0] v);
        return (v == FILL_MAX) ? v : v + FILL_W'(1);
    endfunction

    function automatic logic is_match(input logic [PATTERN_LEN-1:0] h,
                                      input logic [FILL_W-1:0]      f);
        return (h == PATTERN) && (f == FILL_MAX);
    endfunction

    logic [PATTERN_LEN-1:0] hist_p0;
    logic [PATTERN_LEN-1:0] hist_next;
    logic [FILL_W-1:0]      fill_p0;
    logic [FILL_W-1:0]      fill_next;
    logic                   found_p1;

    // The truncating cast drops the oldest bit and also covers PATTERN_LEN == 1.
    always_comb begin
        hist_next = PATTERN_LEN'({hist_p0, bus.in_sig});
        fill_next = sat_inc(fill_p0);
    end

    // Stage p0 -> p1: history/fill update and registered match flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_p0  <= '0;
            fill_p0  <= '0;
            found_p1 <= 1'b0;
        end else begin
            hist_p0  <= hist_next;
            fill_p0  <= fill_next;
            found_p1 <= is_match(hist_next, fill_next);
        end
    end

    assign bus.pattern_found = found_p1;

endmodule

// File: tb/tb_seq_check.sv
// Bench for seq_check: three instances (patterns 110, 101, 000) against a sample-history model.
module tb_seq_check;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    seq_check_if if0 ();
    seq_check_if if1 ();
    seq_check_if if2 ();

    seq_check #(.PATTERN_LEN(3), .PATTERN(3'b110)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    seq_check #(.PATTERN_LEN(3), .PATTERN(3'b101)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    seq_check #(.PATTERN_LEN(3), .PATTERN(3'b000)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: count of samples since reset and the last 32 samples, newest in bit 0.
    int          cnt    [3];
    logic [31:0] recent [3];
    logic [31:0] pats   [3];

    typedef struct {
        logic in_bit;
        logic exp;
    } vec_t;
    vec_t tbl [18];

    function automatic logic model_exp(input int i);
        return (cnt[i] >= 3) && ((recent[i] & 32'h7) == pats[i]);
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            cnt[i]    = 0;
            recent[i] = '0;
        end
    endtask

    // One clock: drive on the falling edge, update model at the rising edge, compare #1 later.
    task automatic tick(input logic [2:0] b, output logic [2:0] got);
        @(negedge clk);
        if0.in_sig = b[0];
        if1.in_sig = b[1];
        if2.in_sig = b[2];
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            for (int i = 0; i < 3; i++) begin
                recent[i] = {recent[i][30:0], b[i]};
                if (cnt[i] < 3) cnt[i]++;
            end
        end
        #1;
        got = {if2.pattern_found, if1.pattern_found, if0.pattern_found};
        chk("model_110", got[0], model_exp(0));
        chk("model_101", got[1], model_exp(1));
        chk("model_000", got[2], model_exp(2));
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear without a clock.
    task automatic mid_reset();
        #1 rst = 1'b1;
        #1;
        chk("async_clr_110", if0.pattern_found, 1'b0);
        chk("async_clr_101", if1.pattern_found, 1'b0);
        chk("async_clr_000", if2.pattern_found, 1'b0);
        model_clear();
        #1 rst = 1'b0;
    endtask

    logic [2:0] got;
    logic [2:0] b;

    initial begin
        checks   = 0;
        failures = 0;
        pats[0]  = 32'b110;
        pats[1]  = 32'b101;
        pats[2]  = 32'b000;
        model_clear();

        tbl[0]  = '{1'b1, 1'b0}; tbl[1]  = '{1'b1, 1'b0}; tbl[2]  = '{1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0}; tbl[4]  = '{1'b1, 1'b0}; tbl[5]  = '{1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0}; tbl[7]  = '{1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0}; tbl[9]  = '{1'b0, 1'b0}; tbl[10] = '{1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0}; tbl[12] = '{1'b1, 1'b0}; tbl[13] = '{1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0}; tbl[15] = '{1'b0, 1'b0}; tbl[16] = '{1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0};

        // Reset held with the clock running and inputs toggling.
        rst        = 1'b1;
        if0.in_sig = 1'b0;
        if1.in_sig = 1'b0;
        if2.in_sig = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b = (k % 2 == 0) ? 3'b111 : 3'b000;
            tick(b, got);
            chk("reset_hold", |got, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Table: basic detect, no false detect, 1,1,1,1,0, near misses.
        for (int k = 0; k < 18; k++) begin
            tick({3{tbl[k].in_bit}}, got);
            chk($sformatf("table_%0d", k), got[0], tbl[k].exp);
        end

        // Reset mid-sequence: 1,1 then reset, then 0 gives nothing; 1,1,0 then fires.
        tick(3'b111, got);
        tick(3'b111, got);
        mid_reset();
        tick(3'b000, got);
        chk("midrst_no_pulse", got[0], 1'b0);
        tick(3'b111, got);
        tick(3'b111, got);
        tick(3'b000, got);
        chk("midrst_pulse", got[0], 1'b1);

        // Overlap for 101 and fill qualification for 000, both from a fresh reset.
        mid_reset();
        tick(3'b000, got); chk("p000_s1", got[2], 1'b0);
        tick(3'b000, got); chk("p000_s2", got[2], 1'b0);
        tick(3'b000, got); chk("p000_s3", got[2], 1'b1);
        tick(3'b000, got); chk("p000_s4", got[2], 1'b1);
        tick(3'b000, got); chk("p000_s5", got[2], 1'b1);
        mid_reset();
        tick(3'b111, got); chk("p101_s1", got[1], 1'b0);
        tick(3'b000, got); chk("p101_s2", got[1], 1'b0);
        tick(3'b111, got); chk("p101_s3", got[1], 1'b1);
        tick(3'b000, got); chk("p101_s4", got[1], 1'b0);
        tick(3'b111, got); chk("p101_s5", got[1], 1'b1);

        // Output high, then an asynchronous reset between edges must drop it at once.
        mid_reset();
        for (int k = 0; k < 3; k++) tick(3'b000, got);
        chk("p000_high_before_rst", got[2], 1'b1);
        mid_reset();

        // Randomised streams with occasional asynchronous resets.
        for (int k = 0; k < 600; k++) begin
            b = 3'($urandom_range(0, 7));
            tick(b, got);
            if ($urandom_range(0, 59) == 0) mid_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
